hazard_ctrl: RTL

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl_pkg.sv | 13 +
 rtl/hazard_ctrl_fwd_unit.sv | 25 ++
 rtl/hazard_ctrl.sv | 118 +++++++++++
 3 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared CPU control definitions: hazard FSM states and operand forwarding selects.
package hazard_ctrl_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } hazState_t;

    localparam logic [1:0] FWD_REGFILE = 2'd0;
    localparam logic [1:0] FWD_EXMEM   = 2'd1;
    localparam logic [1:0] FWD_MEMWB   = 2'd2;

endpackage

// File: rtl/hazard_ctrl_fwd_unit.sv
// Operand forwarding select for one source register; the nearer pipeline stage wins.
module fwd_unit
    import hazard_ctrl_pkg::*;
(
    input  logic [4:0] srcAddr,
    input  logic       memWrite,
    input  logic [4:0] memAddr,
    input  logic       wbWrite,
    input  logic [4:0] wbAddr,
    output logic [1:0] fwdSel
);

    always_comb begin
        fwdSel = FWD_REGFILE;
        // r0 is hardwired to zero, so a pending write to it must never be forwarded
        if (srcAddr != 5'd0) begin
            if (memWrite && (memAddr == srcAddr)) begin
                fwdSel = FWD_EXMEM;
            end else if (wbWrite && (wbAddr == srcAddr)) begin
                fwdSel = FWD_MEMWB;
            end
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard control: memory-wait stalls with timeout, load-use bubbles,
// branch flush tracking, operand forwarding and stall statistics.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [4:0]       iID_rs_addr,
    input  logic [4:0]       iID_rt_addr,
    input  logic             iID_uses_rs,
    input  logic             iID_uses_rt,
    input  logic             iEX_do_dm_read,
    input  logic             iEX_do_reg_write,
    input  logic [4:0]       iEX_write_reg_addr,
    input  logic             iMEM_do_reg_write,
    input  logic [4:0]       iMEM_write_reg_addr,
    input  logic             iWB_do_reg_write,
    input  logic [4:0]       iWB_write_reg_addr,
    input  logic             iMEM_dm_access,
    input  logic             iDM_ready,
    input  logic             iBranch_taken,
    output logic             enable_regwalls,
    output logic             do_hazard,
    output logic             do_flush_REG1,
    output logic [1:0]       oFWD_rs_sel,
    output logic [1:0]       oFWD_rt_sel,
    output logic [CNT_W-1:0] oStall_count,
    output logic             oBus_error
);

    hazState_t  state;
    logic [3:0] waitCnt;
    logic       flushPending;
    logic       waitDone;
    logic       loadUse;
    logic       blocked;
    logic       unusedExWrite;

    // A load always writes its destination, so the EX write enable adds nothing here
    assign unusedExWrite = iEX_do_reg_write;

    assign waitDone = (waitCnt == 4'(MEM_TIMEOUT));

    always_comb begin
        enable_regwalls = 1'b1;
        if (state == RUN) begin
            enable_regwalls = !(iMEM_dm_access && !iDM_ready);
        end else begin
            enable_regwalls = iDM_ready || waitDone;
        end
    end

    assign loadUse = iEX_do_dm_read && (iEX_write_reg_addr != 5'd0) &&
                     ((iID_uses_rs && (iID_rs_addr == iEX_write_reg_addr)) ||
                      (iID_uses_rt && (iID_rt_addr == iEX_write_reg_addr)));

    assign do_hazard     = !reset && loadUse && enable_regwalls;
    assign do_flush_REG1 = !reset && (iBranch_taken || flushPending) &&
                           enable_regwalls && !do_hazard;
    assign blocked       = !enable_regwalls || do_hazard;

    // State follows the pipeline walls on the falling edge
    always_ff @(negedge clock) begin
        if (reset) begin
            state        <= RUN;
            waitCnt      <= 4'd0;
            flushPending <= 1'b0;
            oStall_count <= '0;
            oBus_error   <= 1'b0;
        end else begin
            // Remember a branch that could not flush yet; one flush per branch
            flushPending <= (flushPending || iBranch_taken) && !do_flush_REG1;
            if (blocked && (oStall_count != '1)) begin
                oStall_count <= oStall_count + CNT_W'(1);
            end
            case (state)
                RUN: begin
                    if (!enable_regwalls) begin
                        state   <= MEM_WAIT;
                        waitCnt <= 4'd0;
                    end
                end
                MEM_WAIT: begin
                    if (enable_regwalls) begin
                        state <= RUN;
                        if (!iDM_ready) begin
                            oBus_error <= 1'b1;
                        end
                    end else begin
                        waitCnt <= waitCnt + 4'd1;
                    end
                end
            endcase
        end
    end

    fwd_unit rsFwd (
        .srcAddr (iID_rs_addr),
        .memWrite(iMEM_do_reg_write),
        .memAddr (iMEM_write_reg_addr),
        .wbWrite (iWB_do_reg_write),
        .wbAddr  (iWB_write_reg_addr),
        .fwdSel  (oFWD_rs_sel)
    );

    fwd_unit rtFwd (
        .srcAddr (iID_rt_addr),
        .memWrite(iMEM_do_reg_write),
        .memAddr (iMEM_write_reg_addr),
        .wbWrite (iWB_do_reg_write),
        .wbAddr  (iWB_write_reg_addr),
        .fwdSel  (oFWD_rt_sel)
    );

endmodule
